// File: rtl/i2c_pkg.sv
// i2c_pkg: shared I2C state encoding, bus constants and BME280 register map
package i2c_pkg;
  typedef enum logic [2:0] {IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, IGNORE} i2c_state_t;
  localparam logic ACK = 1'b0;
  localparam logic NACK = 1'b1;
  localparam logic [6:0] BME280_ADDR = 7'h76;
  localparam logic [7:0] CTRL_HUM = 8'hF2;
endpackage

// File: rtl/i2c_bus_cond.sv
// i2c_bus_cond: SCL/SDA synchronizer, optional glitch filter (I2C_TARGET_GLITCH_FILTER_EN), edge and START/STOP detection
module i2c_bus_cond #(
  parameter int FILTER_LEN = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic i_scl,
  input  logic i_sda,
  output logic o_sda,
  output logic o_rise,
  output logic o_fall,
  output logic o_start,
  output logic o_stop
);
  logic [1:0] r_s1, r_s2, r_prev, w_v;
  // two-stage synchronizer; bit 1 is SCL, bit 0 is SDA, both idle high
  always_ff @(posedge clk) begin
    r_s1 <= reset ? 2'b11 : {i_scl, i_sda};
    r_s2 <= reset ? 2'b11 : r_s1;
  end
`ifdef I2C_TARGET_GLITCH_FILTER_EN
  localparam int CW = $clog2(FILTER_LEN + 1);
  logic [1:0] r_flt;
  logic [CW-1:0] r_cnt [2];
  // a line must hold its new level for FILTER_LEN clocks before it is accepted
  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        r_cnt[i] <= '0;
        r_flt[i] <= 1'b1;
      end else if (r_s2[i] == r_flt[i]) r_cnt[i] <= '0;
      else if (r_cnt[i] == CW'(FILTER_LEN - 1)) begin
        r_cnt[i] <= '0;
        r_flt[i] <= r_s2[i];
      end else r_cnt[i] <= r_cnt[i] + CW'(1);
    end
  end
  assign w_v = r_flt;
`else
  logic [31:0] w_unused_flen;
  assign w_unused_flen = FILTER_LEN;
  assign w_v = r_s2;
`endif
  // previous conditioned levels for edge detection
  always_ff @(posedge clk) r_prev <= reset ? 2'b11 : w_v;
  assign o_sda   = w_v[0];
  assign o_rise  = w_v[1] & ~r_prev[1];
  assign o_fall  = ~w_v[1] & r_prev[1];
  assign o_start = w_v[1] & r_prev[0] & ~w_v[0];
  assign o_stop  = w_v[1] & ~r_prev[0] & w_v[0];
endmodule

// File: rtl/i2c_target.sv
// i2c_target: I2C register target at DEV_ADDR with auto-incrementing pointer; glitch filter enabled by I2C_TARGET_GLITCH_FILTER_EN
module i2c_target
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = BME280_ADDR,
  parameter int FILTER_LEN = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  output logic       reg_re,
  input  logic [7:0] reg_rdata,
  output logic       busy
);
  i2c_state_t r_state, w_state;
  logic [3:0] r_cnt, w_cnt;
  logic [7:0] r_sr, w_sr, r_addr, w_addr, r_wdata, w_wdata, w_byte;
  logic r_oe, w_oe, r_we, w_we, r_re, w_re, r_busy, w_busy, r_rw, w_rw, r_first, w_first, r_ld;
  logic w_sda, w_rise, w_fall, w_start, w_stop, w_last, w_match;
  i2c_bus_cond #(.FILTER_LEN(FILTER_LEN)) u_cond (
    .clk(clk), .reset(reset), .i_scl(scl_in), .i_sda(sda_in),
    .o_sda(w_sda), .o_rise(w_rise), .o_fall(w_fall), .o_start(w_start), .o_stop(w_stop)
  );
  assign w_byte  = {r_sr[6:0], w_sda};
  assign w_last  = r_cnt == 4'd7;
  assign w_match = r_sr[6:0] == DEV_ADDR;
  // next state: bus START/STOP first, then per-state SCL edge handling
  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_sr    = r_ld ? reg_rdata : r_sr;
    w_oe    = r_oe;
    w_addr  = r_addr;
    w_wdata = r_wdata;
    w_we    = 1'b0;
    w_re    = 1'b0;
    w_busy  = r_busy;
    w_rw    = r_rw;
    w_first = r_first;
    if (w_stop) begin
      w_state = IDLE;
      w_oe    = 1'b0;
      w_busy  = 1'b0;
    end else if (w_start) begin
      w_state = ADDR;
      w_cnt   = '0;
      w_oe    = 1'b0;
    end else case (r_state)
      ADDR: if (w_rise) begin
        w_sr  = w_byte;
        w_cnt = r_cnt + 4'd1;
        if (w_last) begin
          w_state = w_match ? ADDR_ACK : IGNORE;
          w_busy  = r_busy | w_match;
          w_rw    = w_sda;
          w_first = 1'b1;
        end
      end
      ADDR_ACK: if (w_fall) begin
        w_oe = 1'b1;
        w_re = r_rw;
      end else if (w_rise) begin
        w_state = r_rw ? RD_BYTE : WR_BYTE;
        w_cnt   = '0;
      end
      WR_BYTE: if (w_fall) w_oe = 1'b0;
      else if (w_rise) begin
        w_sr  = w_byte;
        w_cnt = r_cnt + 4'd1;
        if (w_last) begin
          w_state = WR_ACK;
          w_addr  = r_first ? w_byte : r_addr;
          w_wdata = r_first ? r_wdata : w_byte;
          w_we    = ~r_first;
        end
      end
      WR_ACK: if (w_fall) begin
        w_oe    = 1'b1;
        w_addr  = r_first ? r_addr : r_addr + 8'd1;
        w_first = 1'b0;
      end else if (w_rise) begin
        w_state = WR_BYTE;
        w_cnt   = '0;
      end
      RD_BYTE: if (w_fall) w_oe = ~r_sr[7];
      else if (w_rise) begin
        w_sr    = {r_sr[6:0], 1'b0};
        w_cnt   = r_cnt + 4'd1;
        w_state = w_last ? RD_ACK : RD_BYTE;
      end
      RD_ACK: if (w_fall) w_oe = 1'b0;
      else if (w_rise) begin
        w_addr  = r_addr + 8'd1;
        w_re    = w_sda == ACK;
        w_state = w_sda == ACK ? RD_BYTE : IGNORE;
        w_cnt   = '0;
      end
      default: w_oe = 1'b0;
    endcase
  end
  // state and output registers; read data lands the cycle after reg_re
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_sr    <= '0;
      r_oe    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_we    <= 1'b0;
      r_re    <= 1'b0;
      r_busy  <= 1'b0;
      r_rw    <= 1'b0;
      r_first <= 1'b0;
      r_ld    <= 1'b0;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_sr    <= w_sr;
      r_oe    <= w_oe;
      r_addr  <= w_addr;
      r_wdata <= w_wdata;
      r_we    <= w_we;
      r_re    <= w_re;
      r_busy  <= w_busy;
      r_rw    <= w_rw;
      r_first <= w_first;
      r_ld    <= r_re;
    end
  end
  assign sda_oe    = r_oe;
  assign reg_addr  = r_addr;
  assign reg_wdata = r_wdata;
  assign reg_we    = r_we;
  assign reg_re    = r_re;
  assign busy      = r_busy;
endmodule
